// File: rtl/irb_port_arbiter.sv
// Round-robin owner arbiter sharing the single-port IRB between LCD writeback (port 0) and debug (port 1).
// Grants and IRB pins follow the owner combinationally; read data returns one cycle after a read beat.
module irb_port_arbiter #(
    parameter int AW        = 6,
    parameter int DW        = 8,
    parameter int MAX_BURST = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          lock0,
    input  logic          lock1,
    input  logic          wen0,
    input  logic          wen1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          irb_cen,
    output logic          irb_wen,
    output logic [AW-1:0] irb_a,
    output logic [DW-1:0] irb_d,
    input  logic [DW-1:0] irb_q
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tag_vld_q, tag_vld_d;
    logic          tag_port_q, tag_port_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] d_q, d_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    logic          own_vld;
    logic          own_port;
    logic          own_req;
    logic          own_lock;
    logic          own_wen;
    logic          oth_req;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wdata;
    logic          beat;
    logic [CW-1:0] cnt_inc;
    logic          rel;

    always_comb begin
        own_vld   = (state_q != IDLE);
        own_port  = (state_q == OWN1);
        own_req   = own_port ? req1   : req0;
        own_lock  = own_port ? lock1  : lock0;
        own_wen   = own_port ? wen1   : wen0;
        oth_req   = own_port ? req0   : req1;
        own_addr  = own_port ? addr1  : addr0;
        own_wdata = own_port ? wdata1 : wdata0;

        // Reset must suppress a grant even while the owner state is still stale.
        beat = own_vld & own_req & ~reset;
        gnt0 = beat & ~own_port;
        gnt1 = beat &  own_port;

        cnt_inc = (beat && (cnt_q != MAX_C)) ? cnt_q + CW'(1) : cnt_q;
        // The cap is judged on the post-beat count so the capping beat still completes.
        rel = own_vld & ((~own_req & ~own_lock) | ((cnt_inc == MAX_C) & oth_req));

        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_inc;
        case (state_q)
            IDLE: begin
                if (req0 && (!req1 || !ptr_q)) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            default: begin
                if (rel) begin
                    ptr_d   = ~own_port;
                    cnt_d   = '0;
                    state_d = oth_req ? (own_port ? OWN0 : OWN1) : IDLE;
                end
            end
        endcase

        tag_vld_d  = beat & own_wen;
        tag_port_d = own_port;

        a_d     = beat ? own_addr  : a_q;
        d_d     = beat ? own_wdata : d_q;
        irb_cen = ~beat;
        irb_wen = beat ? own_wen : 1'b1;
        irb_a   = reset ? '0 : a_d;
        irb_d   = reset ? '0 : d_d;

        // A tag pending across reset is dropped rather than returned.
        rvalid0  = tag_vld_q & ~tag_port_q & ~reset;
        rvalid1  = tag_vld_q &  tag_port_q & ~reset;
        rdata0_d = rvalid0 ? irb_q : rdata0_q;
        rdata1_d = rvalid1 ? irb_q : rdata1_q;
        rdata0   = reset ? '0 : rdata0_d;
        rdata1   = reset ? '0 : rdata1_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            cnt_q      <= '0;
            tag_vld_q  <= 1'b0;
            tag_port_q <= 1'b0;
            a_q        <= '0;
            d_q        <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            tag_vld_q  <= tag_vld_d;
            tag_port_q <= tag_port_d;
            a_q        <= a_d;
            d_q        <= d_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

endmodule
